fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues in-order word reads to the instruction memory over a request/response handshake. Returned instructions are buffered, tagged with their PC, and presented to decode over a valid/ready interface. Branch/jump redirects from execute flush all buffered and in-flight fetches and restart at the target.

Parameters:
PC_INIT, 32'h01000000, fetch address after reset
DEPTH, 2, instruction buffer entries; also the maximum of (in-flight + buffered) fetches
AW, 32, address/PC width

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  AW  word-aligned fetch address
imem_rsp_valid  input  1  response valid; responses arrive in order, latency >=1 cycle
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  execute-stage control-flow redirect
redirect_pc  input  AW  redirect target
inst_valid  output  1  buffered instruction available to decode
inst_ready  input  1  decode accepts (low = decode stall)
inst_data  output  32  instruction word
inst_pc  output  AW  PC of inst_data

Behaviour:
- Reset: fetch_pc = rsp_pc = PC_INIT; outstanding = 0; discard_cnt = 0; buffer empty. Outputs during and after reset: inst_valid = 0, imem_req_valid = 0 while reset is high, imem_req_addr = PC_INIT. The memory shares this reset, so no response for a pre-reset request arrives after reset.
- Counter widths: outstanding, discard_cnt and count are each $clog2(DEPTH+1) bits. None may overflow or underflow. The verifier asserts this.
- Credit: imem_req_valid = !reset && !redirect_valid && (outstanding + count - deq) < DEPTH, where deq = inst_valid && inst_ready.
- imem_req_addr = fetch_pc, combinationally.
- Request fire (valid && ready): fetch_pc += 4 and outstanding++.
- While req_ready is low, valid and addr stay stable.
- Response arrives (rsp_valid):
  - outstanding--.
  - If discard_cnt > 0: the response is dropped and discard_cnt--.
  - Otherwise {rsp_pc, rsp_data} is pushed into the buffer and rsp_pc += 4.
  - Credit guarantees the buffer is never full on a push. Push while full is an assertion failure.
- Buffer: synchronous FIFO with registered output and no bypass.
  - inst_valid rises the cycle after the accepted response.
  - With 1-cycle memory: request at t, response at t+1, inst_valid at t+2.
  - Steady-state throughput is 1 instruction/cycle when inst_ready is held high.
- Backpressure: while inst_valid && !inst_ready, inst_data and inst_pc hold stable. Fetch stops once credit is exhausted.
- Redirect (redirect_valid=1 in cycle t):
  - No request is issued in t.
  - At the end of t: buffer flushed; fetch_pc = rsp_pc = {redirect_pc[AW-1:2], 2'b00}; discard_cnt = outstanding - imem_rsp_valid (covers all stale in-flight fetches). A response arriving in t is dropped. A dequeue in t is still a valid handshake.
  - In t+1: inst_valid = 0 and requests resume from the target.
- Redirect with discard_cnt already > 0: the rule above still holds, because outstanding already includes the pending discards.
- Back-to-back redirects: the last one wins.
- Redirect and reset together: reset wins.
- Wrap-around: PC arithmetic is modulo 2^AW with no special handling.
- The block has no explicit state machine. State is fetch_pc, rsp_pc, outstanding, discard_cnt and the FIFO.

Decomposition:
- Shared package rv_pkg: PC_INIT_DEFAULT, the INST_W=32 constant, and a fetch_entry_t struct {pc, inst}.
- One sub-module, fetch_fifo: parameterised DEPTH/width synchronous FIFO with push, pop, flush, full/empty and count. It is reusable for other pipeline buffers.

Test Plan:
- Reset, then 1-cycle memory returning 0x00000013 per word, inst_ready=1 → inst_pc 0x01000000, 0x01000004, 0x01000008 on consecutive cycles; first inst_valid 2 cycles after reset deassert.
- Hold inst_ready=0 for 5 cycles after the first valid → inst_pc stays 0x01000000 and data stays stable. No more than DEPTH=2 requests issue, and nothing is lost on release.
- Memory latency 3 with imem_req_ready toggling 1,0,1 → imem_req_addr stable while ready is low; output order and PCs stay sequential.
- Redirect to 0x01000100 with 2 fetches in flight → both stale responses are dropped. Next inst_pc is 0x01000100, and the next imem_req_addr is 0x01000100 the cycle after the redirect.
- Redirect to 0x01000203 in the same cycle as a response → response dropped; next inst_pc is 0x01000200.
- Assert reset mid-stream with the buffer full → the next cycle has inst_valid=0 and imem_req_addr=0x01000000, and the stream restarts from PC_INIT.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the front-end pipeline: reset PC, instruction width
// and the {pc, inst} record carried between fetch and decode.
package rv_pkg;
  localparam logic [31:0] PC_INIT_DEFAULT = 32'h0100_0000;
  localparam int unsigned INST_W = 32;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a registered storage output, no bypass, and a
// single-cycle flush; reusable for other pipeline buffers.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  a_no_push_full: assert property (@(posedge clock) disable iff (reset) !(push && full));
  a_no_pop_empty: assert property (@(posedge clock) disable iff (reset) !(pop && empty));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order reads
// to instruction memory and buffers PC-tagged instructions for decode.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] PC_INIT = PC_INIT_DEFAULT,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned AW      = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [AW-1:0]     imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [AW-1:0]     redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [AW-1:0]     inst_pc
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = AW + INST_W;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] rsp_pc;
  logic [AW-1:0] redirect_tgt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] count;
  logic [CW:0]   in_use;
  logic          deq;
  logic          fire;
  logic          push;
  logic          full;
  logic          empty;
  logic [EW-1:0] head;

  assign redirect_tgt = {redirect_pc[AW-1:2], 2'b00};
  assign deq          = inst_valid && inst_ready;

  // Credit counts in-flight fetches plus buffered entries, net of a dequeue
  // this cycle, so a returning response always finds a free slot.
  assign in_use         = {1'b0, outstanding} + {1'b0, count} - (CW + 1)'(deq);
  assign imem_req_valid = !reset && !redirect_valid && (in_use < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && !redirect_valid && (discard_cnt == '0);

  assign inst_valid         = !empty;
  assign {inst_pc, inst_data} = head;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= AW'(PC_INIT);
      rsp_pc      <= AW'(PC_INIT);
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      // Every fetch still in flight after this cycle is stale.
      fetch_pc    <= redirect_tgt;
      rsp_pc      <= redirect_tgt;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      discard_cnt <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (fire) fetch_pc <= fetch_pc + AW'(4);
      outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
        else                   rsp_pc      <= rsp_pc + AW'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data({rsp_pc, imem_rsp_data}),
    .pop      (deq),
    .flush    (redirect_valid),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  a_rsp_underflow: assert property (@(posedge clock) disable iff (reset)
    !(imem_rsp_valid && outstanding == '0));
  a_req_overflow: assert property (@(posedge clock) disable iff (reset)
    !(fire && outstanding == CW'(DEPTH)));
  a_push_full: assert property (@(posedge clock) disable iff (reset) !(push && full));
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a stream-level model:
// a memory queue plus the expected next fetch and next delivered PC.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] PC0   = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clock = ~clock;

  fetch_unit #(
    .PC_INIT(PC0),
    .DEPTH  (DEPTH),
    .AW     (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: mode 0 is a field of NOPs, mode 1 an address-dependent pattern.
  bit mode = 1'b0;
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return mode ? ((a ^ 32'h5A5A_0F0F) + 32'h0000_1234) : 32'h0000_0013;
  endfunction

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned last_due = 0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // In-order memory: one response per cycle, never before its due cycle.
  initial forever begin
    @(posedge clock);
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
  end

  logic [31:0] exp_pc = PC0;
  logic [31:0] exp_req = PC0;
  int unsigned fire_count = 0;
  int unsigned deliveries = 0;
  bit          prev_reset = 1'b0;
  bit          prev_redirect = 1'b0;
  bit          prev_hold = 1'b0;
  bit          prev_req_wait = 1'b0;
  logic [31:0] prev_pc, prev_data, prev_addr;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      chk(imem_req_valid === 1'b0, "req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
      if (prev_reset) chk(inst_valid === 1'b0, "inst_valid_in_reset", {31'b0, inst_valid}, 32'd0);
      mq.delete();
      last_due      = 0;
      exp_pc        = PC0;
      exp_req       = PC0;
      fire_count    = 0;
      prev_hold     = 1'b0;
      prev_req_wait = 1'b0;
      prev_redirect = 1'b0;
    end else begin
      if (prev_reset || prev_redirect)
        chk(inst_valid === 1'b0, "valid_after_flush", {31'b0, inst_valid}, 32'd0);
      if (prev_hold) begin
        chk(inst_valid === 1'b1, "hold_valid", {31'b0, inst_valid}, 32'd1);
        chk(inst_pc === prev_pc, "hold_pc", inst_pc, prev_pc);
        chk(inst_data === prev_data, "hold_data", inst_data, prev_data);
      end
      if (redirect_valid)
        chk(imem_req_valid === 1'b0, "no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
      if (prev_req_wait && !redirect_valid) begin
        chk(imem_req_valid === 1'b1, "req_valid_stable", {31'b0, imem_req_valid}, 32'd1);
        chk(imem_req_addr === prev_addr, "req_addr_stable", imem_req_addr, prev_addr);
      end
      if (imem_req_valid === 1'b1)
        chk(imem_req_addr === exp_req, "req_addr", imem_req_addr, exp_req);
      if (inst_valid === 1'b1 && inst_ready) begin
        chk(inst_pc === exp_pc, "inst_pc", inst_pc, exp_pc);
        chk(inst_data === memfn(exp_pc), "inst_data", inst_data, memfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (imem_rsp_valid) void'(mq.pop_front());
      if (imem_req_valid === 1'b1 && imem_req_ready) begin
        int unsigned due;
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        mq.push_back('{data: memfn(imem_req_addr), due: due});
        exp_req = exp_req + 32'd4;
        fire_count++;
        chk(mq.size() <= DEPTH, "inflight_limit", mq.size(), DEPTH);
      end
      if (redirect_valid) begin
        exp_pc  = {redirect_pc[31:2], 2'b00};
        exp_req = {redirect_pc[31:2], 2'b00};
      end
      prev_hold     = (inst_valid === 1'b1) && !inst_ready && !redirect_valid;
      prev_req_wait = (imem_req_valid === 1'b1) && !imem_req_ready;
      prev_redirect = redirect_valid;
    end
    prev_reset = reset;
    prev_pc    = inst_pc;
    prev_data  = inst_data;
    prev_addr  = imem_req_addr;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input bit m);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    mode           = m;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_deq(input string name, output logic [31:0] pc);
    bit got = 1'b0;
    pc = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (inst_valid === 1'b1 && inst_ready) begin
        pc  = inst_pc;
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(1'b0, {name, "_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc;
    int unsigned n;
    int unsigned d0;

    // Steady stream with 1-cycle memory
    inst_ready = 1'b1; imem_req_ready = 1'b1; lat = 1;
    do_reset(1'b0);
    n = 0;
    while (n < 20) begin
      @(negedge clock);
      if (inst_valid === 1'b1) break;
      n++;
    end
    chk(n == 2, "first_valid_latency", n, 32'd2);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      chk(inst_valid === 1'b1, "seq_valid", {31'b0, inst_valid}, 32'd1);
      chk(inst_pc === PC0 + 32'(4 * k), "seq_pc", inst_pc, PC0 + 32'(4 * k));
      chk(inst_data === 32'h0000_0013, "seq_data", inst_data, 32'h0000_0013);
    end
    step();

    // Decode stall right after the first instruction
    inst_ready = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (inst_valid === 1'b1) break;
    end
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk(inst_valid === 1'b1 && inst_pc === PC0, "stall_pc", inst_pc, PC0);
      step();
    end
    chk(fire_count == 2, "stall_fire_count", fire_count, 32'd2);
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_deq("release", pc);
      chk(pc === PC0 + 32'(4 * k), "release_pc", pc, PC0 + 32'(4 * k));
    end

    // Latency 3 with request-side backpressure
    do_reset(1'b1);
    lat = 3;
    d0  = deliveries;
    for (int i = 0; i < 30; i++) begin
      imem_req_ready = (i % 3) != 1;
      step();
    end
    chk(deliveries - d0 >= 5, "lat3_progress", deliveries - d0, 32'd5);

    // Redirect with two fetches in flight
    imem_req_ready = 1'b1;
    do_reset(1'b1);
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 2) break;
      step();
    end
    chk(mq.size() == 2, "two_in_flight", mq.size(), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0100;
    step();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk(imem_req_addr === 32'h0100_0100, "redirect_addr", imem_req_addr, 32'h0100_0100);
    wait_deq("redirect", pc);
    chk(pc === 32'h0100_0100, "redirect_pc", pc, 32'h0100_0100);

    // Redirect to an unaligned target coinciding with a response
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #2;
      if (imem_rsp_valid) break;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0203;
    step();
    redirect_valid = 1'b0;
    wait_deq("redirect_rsp", pc);
    chk(pc === 32'h0100_0200, "redirect_rsp_pc", pc, 32'h0100_0200);

    // Reset mid-stream with the buffer full
    inst_ready = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk(inst_valid === 1'b0, "reset_mid_valid", {31'b0, inst_valid}, 32'd0);
    chk(imem_req_addr === PC0, "reset_mid_addr", imem_req_addr, PC0);
    inst_ready = 1'b1;
    step();
    wait_deq("reset_mid", pc);
    chk(pc === PC0, "reset_mid_pc", pc, PC0);

    // PC wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_deq("wrap", pc);
      chk(pc === 32'hFFFF_FFF8 + 32'(4 * k), "wrap_pc", pc, 32'hFFFF_FFF8 + 32'(4 * k));
    end

    // Random traffic
    d0 = deliveries;
    for (int i = 0; i < 3000; i++) begin
      inst_ready     = $urandom_range(0, 3) != 0;
      imem_req_ready = $urandom_range(0, 3) != 0;
      lat            = $urandom_range(1, 4);
      redirect_valid = $urandom_range(0, 31) == 0;
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom() : PC0 + 32'($urandom_range(0, 1023));
      reset          = $urandom_range(0, 299) == 0;
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (30) step();
    chk(deliveries - d0 >= 200, "random_progress", deliveries - d0, 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
